// File: rtl/wbu_commit_queue_pkg.sv
// Shared definitions for the write-back commit queue.
//   - Result source index constants (ALU, LSU, CSR, PC+4).
//   - sel_width(): width of a source select index, never below 1 bit.
//   - wbu_entry_t: queue entry layout {pc, rd, wen, data} at the default
//     widths, for consumers that do not override the block parameters.
package wbu_commit_queue_pkg;

    localparam int SRC_ALU = 0;
    localparam int SRC_LSU = 1;
    localparam int SRC_CSR = 2;
    localparam int SRC_PC4 = 3;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_REG_AW = 5;
    localparam int DEF_NSRC   = 4;

    // Select index width: max(1, clog2(nsrc)).
    function automatic int sel_width(input int nsrc);
        return (nsrc > 1) ? $clog2(nsrc) : 1;
    endfunction

    localparam int SEL_W = sel_width(DEF_NSRC);

    typedef struct packed {
        logic [DEF_DATA_W-1:0] pc;
        logic [DEF_REG_AW-1:0] rd;
        logic                  wen;
        logic [DEF_DATA_W-1:0] data;
    } wbu_entry_t;

endpackage

// File: rtl/wbu_commit_queue_src_mux.sv
// Combinational NSRC:1 result source select.
//   src_data : flattened sources, source k at [k*DATA_W +: DATA_W]
//   sel      : source index
//   data     : selected result, zero when sel does not name a source
//   illegal  : sel >= NSRC
module wbu_src_mux #(
    parameter int DATA_W = 32,
    parameter int NSRC   = 4,
    parameter int SEL_W  = 2
) (
    input  logic [NSRC*DATA_W-1:0] src_data,
    input  logic [SEL_W-1:0]       sel,
    output logic [DATA_W-1:0]      data,
    output logic                   illegal
);

    logic [NSRC-1:0] hit;

    // One-hot decode of sel, then AND-OR select; no hit means illegal and data 0.
    always_comb begin
        hit  = '0;
        data = '0;
        for (int k = 0; k < NSRC; k++) begin
            hit[k] = (sel == SEL_W'(k));
            data   = data | (src_data[k*DATA_W +: DATA_W] & {DATA_W{hit[k]}});
        end
        illegal = ~|hit;
    end

endmodule

// File: rtl/wbu_commit_queue.sv
// Write-back commit queue: selects a result source on acceptance, buffers
// up to DEPTH completed instructions in order and retires the head one per
// out_valid/out_ready handshake, driving the regfile write port.
//   clock, reset         : clock, synchronous active-high reset
//   in_valid/in_ready    : upstream completion handshake
//   in_src_data/_sel     : flattened source results and source index
//   in_rd, in_rd_wen     : destination register and its write enable
//   in_pc                : instruction PC carried to commit
//   out_valid/out_ready  : retirement handshake; out_pc is the head PC
//   rf_wen/_waddr/_wdata : regfile write port (pulses on retirement)
//   sel_err              : sticky, an illegal source index was accepted
//   retire_cnt           : retired instruction count (wraps)
module wbu_commit_queue
    import wbu_commit_queue_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int NSRC   = 4,
    parameter int REG_AW = 5,
    parameter int DEPTH  = 2,
    parameter int CNT_W  = 32
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [NSRC*DATA_W-1:0]    in_src_data,
    input  logic [sel_width(NSRC)-1:0] in_src_sel,
    input  logic [REG_AW-1:0]         in_rd,
    input  logic                      in_rd_wen,
    input  logic [DATA_W-1:0]         in_pc,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_W-1:0]         out_pc,
    output logic                      rf_wen,
    output logic [REG_AW-1:0]         rf_waddr,
    output logic [DATA_W-1:0]         rf_wdata,
    output logic                      sel_err,
    output logic [CNT_W-1:0]          retire_cnt
);

    localparam int Q_SEL_W = sel_width(NSRC);
    localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OCC_W   = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [DATA_W-1:0] pc;
        logic [REG_AW-1:0] rd;
        logic              wen;
        logic [DATA_W-1:0] data;
    } entry_t;

    entry_t             mem_q [DEPTH];
    entry_t             mem_d [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]   count_q, count_d;
    logic [CNT_W-1:0]   retire_cnt_q, retire_cnt_d;
    logic               sel_err_q, sel_err_d;

    logic [DATA_W-1:0]  sel_data;
    logic               sel_illegal;
    entry_t             new_entry;
    entry_t             head;
    logic               push;
    logic               pop;

    wbu_src_mux #(
        .DATA_W (DATA_W),
        .NSRC   (NSRC),
        .SEL_W  (Q_SEL_W)
    ) u_src_mux (
        .src_data (in_src_data),
        .sel      (in_src_sel),
        .data     (sel_data),
        .illegal  (sel_illegal)
    );

    // in_ready depends only on the occupancy register, so a pop never frees
    // a slot for a push in the same cycle. Handshakes are masked during
    // reset so nothing is written or retired in the reset cycle.
    assign head       = mem_q[rd_ptr_q];
    assign in_ready   = (count_q < OCC_W'(DEPTH));
    assign out_valid  = (count_q != '0);
    assign push       = in_valid & in_ready & ~reset;
    assign pop        = out_valid & out_ready & ~reset;
    assign out_pc     = head.pc;
    assign rf_waddr   = head.rd;
    assign rf_wdata   = head.data;
    assign rf_wen     = pop & head.wen & (head.rd != '0);
    assign sel_err    = sel_err_q;
    assign retire_cnt = retire_cnt_q;

    // Entry captured at push; an illegal select yields data 0 and no write.
    always_comb begin
        new_entry      = '0;
        new_entry.pc   = in_pc;
        new_entry.rd   = in_rd;
        new_entry.wen  = in_rd_wen & ~sel_illegal;
        new_entry.data = sel_data;
    end

    // Next-state for queue storage, pointers, occupancy, counter and sticky error.
    always_comb begin
        mem_d        = mem_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        retire_cnt_d = retire_cnt_q;
        sel_err_d    = sel_err_q;
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_d[i] = '0;
            end
            wr_ptr_d     = '0;
            rd_ptr_d     = '0;
            count_d      = '0;
            retire_cnt_d = '0;
            sel_err_d    = 1'b0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = new_entry;
                wr_ptr_d        = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
                sel_err_d       = sel_err_q | sel_illegal;
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_d     = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
                retire_cnt_d = retire_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + OCC_W'(1);
                2'b01:   count_d = count_q - OCC_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // State registers; reset is folded into the _d logic above.
    always_ff @(posedge clock) begin
        mem_q        <= mem_d;
        wr_ptr_q     <= wr_ptr_d;
        rd_ptr_q     <= rd_ptr_d;
        count_q      <= count_d;
        retire_cnt_q <= retire_cnt_d;
        sel_err_q    <= sel_err_d;
    end

endmodule

// File: tb/tb_wbu_commit_queue.sv
// Self-checking bench for wbu_commit_queue. NSRC=3 is used so that the
// 2-bit select still has an unused code (3) and illegal selects are reachable.
module tb_wbu_commit_queue;

    localparam int DATA_W = 32;
    localparam int NSRC   = 3;
    localparam int REG_AW = 5;
    localparam int DEPTH  = 2;
    localparam int CNT_W  = 32;

    logic                   clock = 1'b0;
    logic                   reset;
    logic                   in_valid;
    logic                   in_ready;
    logic [NSRC*DATA_W-1:0] in_src_data;
    logic [1:0]             in_src_sel;
    logic [REG_AW-1:0]      in_rd;
    logic                   in_rd_wen;
    logic [DATA_W-1:0]      in_pc;
    logic                   out_valid;
    logic                   out_ready;
    logic [DATA_W-1:0]      out_pc;
    logic                   rf_wen;
    logic [REG_AW-1:0]      rf_waddr;
    logic [DATA_W-1:0]      rf_wdata;
    logic                   sel_err;
    logic [CNT_W-1:0]       retire_cnt;

    always #5 clock = ~clock;

    wbu_commit_queue #(
        .DATA_W(DATA_W), .NSRC(NSRC), .REG_AW(REG_AW), .DEPTH(DEPTH), .CNT_W(CNT_W)
    ) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_src_data(in_src_data), .in_src_sel(in_src_sel),
        .in_rd(in_rd), .in_rd_wen(in_rd_wen), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .sel_err(sel_err), .retire_cnt(retire_cnt)
    );

    // Reference model: an in-order list of accepted instructions.
    typedef struct {
        logic [DATA_W-1:0] pc;
        logic [REG_AW-1:0] rd;
        logic              wen;
        logic [DATA_W-1:0] data;
    } m_entry_t;

    m_entry_t          mq[$];
    logic [CNT_W-1:0]  m_retire;
    logic              m_sel_err;
    logic [DATA_W-1:0] retired_pcs[$];

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [1:0]        sel;
        logic [DATA_W-1:0] data;
        logic [REG_AW-1:0] rd;
        logic              wen;
        logic [DATA_W-1:0] pc;
        logic              exp_wen;
        logic [DATA_W-1:0] exp_wdata;
    } vec_t;

    vec_t vt[5];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock cycle: inputs were driven just after a negedge. Check the
    // settled outputs against the model, advance the model, wait next negedge.
    task automatic tick();
        logic     exp_pop;
        logic     exp_push;
        logic     exp_wen;
        m_entry_t e;
        int       s;
        #1;
        chk("in_ready", 64'(in_ready), 64'(mq.size() < DEPTH));
        chk("out_valid", 64'(out_valid), 64'(mq.size() != 0));
        chk("retire_cnt", 64'(retire_cnt), 64'(m_retire));
        chk("sel_err", 64'(sel_err), 64'(m_sel_err));
        exp_pop = !reset && (mq.size() != 0) && out_ready;
        exp_wen = exp_pop && mq[0].wen && (mq[0].rd != 0);
        chk("rf_wen", 64'(rf_wen), 64'(exp_wen));
        if (mq.size() != 0) begin
            chk("out_pc", 64'(out_pc), 64'(mq[0].pc));
            chk("rf_waddr", 64'(rf_waddr), 64'(mq[0].rd));
            chk("rf_wdata", 64'(rf_wdata), 64'(mq[0].data));
        end
        if (exp_pop) retired_pcs.push_back(out_pc);
        if (reset) begin
            mq.delete();
            m_retire  = '0;
            m_sel_err = 1'b0;
        end else begin
            exp_push = in_valid && (mq.size() < DEPTH);
            if (exp_pop) begin
                void'(mq.pop_front());
                m_retire = m_retire + 1;
            end
            if (exp_push) begin
                s     = int'(in_src_sel);
                e.pc  = in_pc;
                e.rd  = in_rd;
                if (s < NSRC) begin
                    e.data = in_src_data[s*DATA_W +: DATA_W];
                    e.wen  = in_rd_wen;
                end else begin
                    e.data = '0;
                    e.wen  = 1'b0;
                    m_sel_err = 1'b1;
                end
                mq.push_back(e);
            end
        end
        @(negedge clock);
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        in_valid = 1'b0;
        tick();
        reset    = 1'b0;
    endtask

    task automatic set_in(input logic [1:0] sel, input logic [DATA_W-1:0] data,
                          input logic [REG_AW-1:0] rd, input logic wen, input logic [DATA_W-1:0] pc);
        for (int k = 0; k < NSRC; k++) in_src_data[k*DATA_W +: DATA_W] = 32'h5A5A_0000 | k;
        if (int'(sel) < NSRC) in_src_data[int'(sel)*DATA_W +: DATA_W] = data;
        in_src_sel = sel;
        in_rd      = rd;
        in_rd_wen  = wen;
        in_pc      = pc;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0] = '{sel: 2'd1, data: 32'hDEAD_BEEF, rd: 5'd5,  wen: 1'b1, pc: 32'h0000_1000, exp_wen: 1'b1, exp_wdata: 32'hDEAD_BEEF};
        vt[1] = '{sel: 2'd0, data: 32'h0000_1234, rd: 5'd0,  wen: 1'b1, pc: 32'h0000_1004, exp_wen: 1'b0, exp_wdata: 32'h0000_1234};
        vt[2] = '{sel: 2'd2, data: 32'hCAFE_F00D, rd: 5'd31, wen: 1'b1, pc: 32'h0000_1008, exp_wen: 1'b1, exp_wdata: 32'hCAFE_F00D};
        vt[3] = '{sel: 2'd0, data: 32'h7777_0001, rd: 5'd7,  wen: 1'b0, pc: 32'h0000_100C, exp_wen: 1'b0, exp_wdata: 32'h7777_0001};
        vt[4] = '{sel: 2'd3, data: 32'h1111_2222, rd: 5'd9,  wen: 1'b1, pc: 32'h0000_1010, exp_wen: 1'b0, exp_wdata: 32'h0000_0000};

        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        set_in(2'd0, 32'h0, 5'd0, 1'b0, 32'h0);
        @(negedge clock);
        @(negedge clock);
        mq.delete(); m_retire = '0; m_sel_err = 1'b0;
        reset = 1'b0;

        // Reset state
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_retire_cnt", 64'(retire_cnt), 64'd0);
        tick();

        // Table: push one entry, check its retirement next cycle
        for (int i = 0; i < 5; i++) begin
            set_in(vt[i].sel, vt[i].data, vt[i].rd, vt[i].wen, vt[i].pc);
            in_valid  = 1'b1;
            out_ready = 1'b1;
            tick();
            in_valid = 1'b0;
            #1;
            chk($sformatf("vec%0d_out_valid", i), 64'(out_valid), 64'd1);
            chk($sformatf("vec%0d_rf_wen", i), 64'(rf_wen), 64'(vt[i].exp_wen));
            chk($sformatf("vec%0d_rf_waddr", i), 64'(rf_waddr), 64'(vt[i].rd));
            chk($sformatf("vec%0d_rf_wdata", i), 64'(rf_wdata), 64'(vt[i].exp_wdata));
            chk($sformatf("vec%0d_retire_cnt", i), 64'(retire_cnt), 64'(i));
            tick();
        end
        chk("sel_err_set", 64'(sel_err), 64'd1);
        for (int i = 0; i < 5; i++) tick();
        chk("sel_err_sticky", 64'(sel_err), 64'd1);
        do_reset();
        chk("sel_err_cleared", 64'(sel_err), 64'd0);

        // Backpressure: three pushes into a 2-deep queue, then drain in order
        retired_pcs.delete();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        set_in(2'd0, 32'hA0, 5'd1, 1'b1, 32'h8000_0000); tick();
        set_in(2'd1, 32'hA1, 5'd2, 1'b1, 32'h8000_0004); tick();
        set_in(2'd2, 32'hA2, 5'd3, 1'b1, 32'h8000_0008);
        chk("full_in_ready", 64'(in_ready), 64'd0);
        tick();
        out_ready = 1'b1;
        tick();
        chk("full_pop_no_push", 64'(retire_cnt), 64'd1);
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        chk("bp_retired_n", 64'(retired_pcs.size()), 64'd3);
        if (retired_pcs.size() == 3) begin
            chk("bp_pc0", 64'(retired_pcs[0]), 64'h8000_0000);
            chk("bp_pc1", 64'(retired_pcs[1]), 64'h8000_0004);
            chk("bp_pc2", 64'(retired_pcs[2]), 64'h8000_0008);
        end

        // Streaming at occupancy 1 for 10 cycles
        do_reset();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        set_in(2'd0, 32'h100, 5'd4, 1'b1, 32'h9000_0000); tick();
        out_ready = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            set_in(2'(i % 3), 32'h100 + i, 5'(i), 1'b1, 32'h9000_0000 + 32'(4*i));
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        #1;
        chk("stream_retire_cnt", 64'(retire_cnt), 64'd10);
        chk("stream_out_valid", 64'(out_valid), 64'd1);
        chk("stream_out_pc", 64'(out_pc), 64'h9000_0028);
        tick();

        // Reset with a full queue
        do_reset();
        in_valid = 1'b1;
        out_ready = 1'b0;
        set_in(2'd1, 32'hBB, 5'd6, 1'b1, 32'hA000_0000); tick();
        set_in(2'd1, 32'hCC, 5'd7, 1'b1, 32'hA000_0004); tick();
        in_valid = 1'b0;
        reset = 1'b1;
        out_ready = 1'b1;
        #1;
        chk("rst_full_no_wen", 64'(rf_wen), 64'd0);
        tick();
        reset = 1'b0;
        #1;
        chk("post_rst_out_valid", 64'(out_valid), 64'd0);
        chk("post_rst_in_ready", 64'(in_ready), 64'd1);
        chk("post_rst_retire_cnt", 64'(retire_cnt), 64'd0);
        chk("post_rst_rf_wen", 64'(rf_wen), 64'd0);
        tick();

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            in_valid    = 1'($urandom_range(1, 0));
            out_ready   = ($urandom_range(3, 0) != 0);
            in_src_data = {$urandom, $urandom, $urandom};
            in_src_sel  = 2'($urandom_range(3, 0));
            in_rd       = 5'($urandom_range(31, 0));
            in_rd_wen   = 1'($urandom_range(1, 0));
            in_pc       = $urandom;
            reset       = ($urandom_range(63, 0) == 0);
            tick();
        end
        reset = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
